hralm_pipe: RTL and testbench

- Parametrised, pipelined successor of the 16-bit hybrid radix-4 / approximate-logarithmic signed multiplier.
- Operand width is generic, the pipeline has three stages with a valid/ready handshake, and a per-transaction mode selects the approximate log low path or an exact low path.
- Sits as a drop-in multiply unit behind datapath stages that need backpressure.
- A caller tag travels alongside each operation.

---
 rtl/hralm_pkg.sv | 49 ++++
 rtl/hralm_log_pp.sv | 35 +++
 rtl/hralm_pipe.sv | 157 +++++++++++++++
 tb/tb_hralm_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hralm_pkg.sv
// Shared types and helpers for the pipelined hybrid Booth / approximate-log multiplier.
package hralm_pkg;

    localparam int unsigned LOD_MAX_W = 64;
    localparam int unsigned LOD_IW    = 6;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_t;

    // Radix-4 recoding of the top three multiplicand bits
    function automatic booth_t booth_enc(input logic [2:0] g);
        booth_t b;
        b.one = g[0] ^ g[1];
        b.two = ~b.one & (g[2] ^ g[1]);
        b.neg = g[2];
        return b;
    endfunction

    function automatic int unsigned log_w(input int unsigned n);
        return $clog2(n) + 2;
    endfunction

    function automatic int unsigned antilog_w(input int unsigned n);
        return 2 * n - 2;
    endfunction

    function automatic int unsigned lod_index(input logic [LOD_MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < LOD_MAX_W; i++) begin
            if (v[LOD_IW'(i)]) idx = i;
        end
        return idx;
    endfunction

    // Bit just below the leading one; zero when the leading one is bit 0
    function automatic logic lod_frac(input logic [LOD_MAX_W-1:0] v);
        logic f;
        f = 1'b0;
        for (int unsigned i = 1; i < LOD_MAX_W; i++) begin
            if (v[LOD_IW'(i)]) f = v[LOD_IW'(i - 1)];
        end
        return f;
    endfunction

endpackage

// File: rtl/hralm_log_pp.sv
// Approximate low partial product: add the two log values, take the antilog, apply a one's-complement sign.
module hralm_log_pp
    import hralm_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [$clog2(N)-1:0] kx_i,
    input  logic                 fx_i,
    input  logic [$clog2(N)-1:0] ky_i,
    input  logic                 fy_i,
    input  logic                 neg_i,
    input  logic                 zero_i,
    output logic [2*N-3:0]       pp0_c
);

    localparam int unsigned LW = log_w(N);
    localparam int unsigned SW = LW + 1;
    localparam int unsigned PW = antilog_w(N);
    localparam int unsigned AW = 2 * N;

    logic [LW-1:0] lx_c;
    logic [LW-1:0] ly_c;
    logic [SW-1:0] s_c;
    logic [AW-1:0] a_c;

    // Shift never exceeds 2N-3, so the 2N-bit antilog cannot overflow
    always_comb begin
        lx_c  = {kx_i, fx_i, 1'b1};
        ly_c  = {ky_i, fy_i, 1'b1};
        s_c   = SW'(lx_c) + SW'(ly_c);
        a_c   = AW'({1'b1, s_c[1:0]}) << s_c[SW-1:2];
        pp0_c = zero_i ? '0 : (PW'(a_c >> 2) ^ {PW{neg_i}});
    end

endmodule

// File: rtl/hralm_pipe.sv
// Three-stage hybrid radix-4 / approximate-log signed multiplier with a global-stall valid/ready pipeline.
module hralm_pipe
    import hralm_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode
);

    localparam int unsigned K   = N - 2;
    localparam int unsigned KW  = $clog2(N);
    localparam int unsigned PW  = antilog_w(N);
    localparam int unsigned HW  = N + 2;
    localparam int unsigned P1W = N + 1;

    logic en_c;

    logic             s1_valid_q, s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [K-1:0]     s1_x0_q;
    logic [N-1:0]     s1_y_q;
    booth_t           s1_booth_q, s1_booth_d;
    logic [KW-1:0]    s1_kx_q, s1_kx_d, s1_ky_q, s1_ky_d;
    logic             s1_fx_q, s1_fx_d, s1_fy_q, s1_fy_d;
    logic             s1_neg_q, s1_neg_d, s1_zero_q, s1_zero_d;

    logic             s2_valid_q, s2_mode_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [P1W-1:0]   s2_pp1_q, s2_pp1_d;
    logic             s2_sf_q, s2_sf_d;
    logic [PW-1:0]    s2_pp0_q, s2_pp0_d;

    logic             out_valid_q, out_mode_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [2*N-1:0]   out_p_q, out_p_d;

    logic [K-1:0]         x0_c, ax_c;
    logic [N-1:0]         ay_c;
    logic [P1W-1:0]       ys_c;
    logic signed [PW-1:0] xe_c, ye_c;
    logic [PW-1:0]        pp0_log_c;
    logic [HW-1:0]        hi_c;

    assign en_c      = ~out_valid_q | out_ready;
    assign in_ready  = en_c;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;
    assign out_mode  = out_mode_q;

    // Stage 1: Booth encode of the high group and leading-one detection on one's-complement magnitudes
    always_comb begin
        x0_c       = in_x[K-1:0];
        ax_c       = x0_c ^ {K{x0_c[K-1]}};
        ay_c       = in_y ^ {N{in_y[N-1]}};
        s1_booth_d = booth_enc(in_x[N-1:N-3]);
        s1_kx_d    = KW'(lod_index(LOD_MAX_W'(ax_c)));
        s1_fx_d    = lod_frac(LOD_MAX_W'(ax_c));
        s1_ky_d    = KW'(lod_index(LOD_MAX_W'(ay_c)));
        s1_fy_d    = lod_frac(LOD_MAX_W'(ay_c));
        s1_neg_d   = x0_c[K-1] ^ in_y[N-1];
        s1_zero_d  = (ax_c == '0) || (ay_c == '0);
    end

    hralm_log_pp #(.N(N)) u_log_pp (
        .kx_i   (s1_kx_q),
        .fx_i   (s1_fx_q),
        .ky_i   (s1_ky_q),
        .fy_i   (s1_fy_q),
        .neg_i  (s1_neg_q),
        .zero_i (s1_zero_q),
        .pp0_c  (pp0_log_c)
    );

    // Stage 2: Booth row (one's complement, +1 carried in sign_factor) and the mode-selected low product
    always_comb begin
        ys_c     = {s1_y_q[N-1], s1_y_q};
        s2_pp1_d = ((ys_c ^ {P1W{s1_booth_q.neg}}) & {P1W{s1_booth_q.one}})
                 | (({ys_c[P1W-2:0], 1'b0} ^ {P1W{s1_booth_q.neg}}) & {P1W{s1_booth_q.two}});
        s2_sf_d  = s1_booth_q.neg & (s1_booth_q.one | s1_booth_q.two);
        xe_c     = {{(PW-K){s1_x0_q[K-1]}}, s1_x0_q};
        ye_c     = {{(PW-N){s1_y_q[N-1]}}, s1_y_q};
        s2_pp0_d = s1_mode_q ? pp0_log_c : PW'(xe_c * ye_c);
    end

    // Stage 3: high part aligned at bit K, low K bits pass straight through
    always_comb begin
        hi_c    = {{2{s2_pp0_q[PW-1]}}, s2_pp0_q[PW-1:K]}
                + {s2_pp1_q[P1W-1], s2_pp1_q}
                + HW'(s2_sf_q);
        out_p_d = {hi_c, s2_pp0_q[K-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_tag_q    <= '0;
            s1_x0_q     <= '0;
            s1_y_q      <= '0;
            s1_booth_q  <= '0;
            s1_kx_q     <= '0;
            s1_fx_q     <= 1'b0;
            s1_ky_q     <= '0;
            s1_fy_q     <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_tag_q    <= '0;
            s2_pp1_q    <= '0;
            s2_sf_q     <= 1'b0;
            s2_pp0_q    <= '0;
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_tag_q   <= '0;
            out_p_q     <= '0;
        end else if (en_c) begin
            s1_valid_q  <= in_valid;
            s1_mode_q   <= in_mode;
            s1_tag_q    <= in_tag;
            s1_x0_q     <= x0_c;
            s1_y_q      <= in_y;
            s1_booth_q  <= s1_booth_d;
            s1_kx_q     <= s1_kx_d;
            s1_fx_q     <= s1_fx_d;
            s1_ky_q     <= s1_ky_d;
            s1_fy_q     <= s1_fy_d;
            s1_neg_q    <= s1_neg_d;
            s1_zero_q   <= s1_zero_d;
            s2_valid_q  <= s1_valid_q;
            s2_mode_q   <= s1_mode_q;
            s2_tag_q    <= s1_tag_q;
            s2_pp1_q    <= s2_pp1_d;
            s2_sf_q     <= s2_sf_d;
            s2_pp0_q    <= s2_pp0_d;
            out_valid_q <= s2_valid_q;
            out_mode_q  <= s2_mode_q;
            out_tag_q   <= s2_tag_q;
            out_p_q     <= out_p_d;
        end
    end

endmodule

// File: tb/tb_hralm_pipe.sv
// Randomised scoreboard bench for hralm_pipe against an arithmetic reference of the multiplier.
module tb_hralm_pipe;

    localparam int unsigned N     = 16;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned K     = N - 2;
    localparam int unsigned P_W   = 2 * N;

    typedef struct {
        logic [P_W-1:0]   p;
        logic [TAG_W-1:0] tag;
        logic             mode;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_mode;
    logic [N-1:0]     in_x, in_y;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, out_mode;
    logic [P_W-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    exp_t             sb[$];
    exp_t             mon_e;
    logic             stall_prev = 1'b0;
    logic [P_W-1:0]   prev_p;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_mode;

    hralm_pipe #(.N(N), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int msb_idx(input longint v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if (((v >> i) & 1) != 0) r = i;
        end
        return r;
    endfunction

    // Product as x = booth(G)*2^K + x0: exact x0*y, or the log-domain estimate of x0*y
    function automatic logic [P_W-1:0] model_p(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic mode);
        longint xs, ys, x0, booth, ax, ay, a, lo;
        int     kx, ky, fx, fy, s;
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        if (!mode) return P_W'(xs * ys);
        x0 = xs & ((longint'(1) << K) - 1);
        if (x0 >= (longint'(1) << (K - 1))) x0 = x0 - (longint'(1) << K);
        booth = (xs - x0) / (longint'(1) << K);
        ax = (x0 < 0) ? -x0 - 1 : x0;
        ay = (ys < 0) ? -ys - 1 : ys;
        lo = 0;
        if (ax != 0 && ay != 0) begin
            kx = msb_idx(ax);
            ky = msb_idx(ay);
            fx = (kx > 0) ? int'((ax >> (kx - 1)) & 1) : 0;
            fy = (ky > 0) ? int'((ay >> (ky - 1)) & 1) : 0;
            s  = (4 * kx + 2 * fx + 1) + (4 * ky + 2 * fy + 1);
            a  = (longint'(4 + s % 4) << (s / 4)) >> 2;
            lo = ((x0 < 0) != (ys < 0)) ? -a - 1 : a;
        end
        return P_W'(booth * ys * (longint'(1) << K) + lo);
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] v;
        v = N'($urandom);
        case ($urandom_range(9))
            0: v = '0;
            1: v = '1;
            2: v = {1'b1, {(N-1){1'b0}}};
            3: v = {1'b0, {(N-1){1'b1}}};
            4: v[K-1:0] = '0;
            5: v[K-1:0] = '1;
            6: v = N'($urandom_range(15));
            default: ;
        endcase
        return v;
    endfunction

    // Scoreboard: push on accept, pop and compare on drain, check hold while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", 64'(out_valid), 64'd1);
                check_eq("hold_p", 64'(out_p), 64'(prev_p));
                check_eq("hold_tag", 64'(out_tag), 64'(prev_tag));
                check_eq("hold_mode", 64'(out_mode), 64'(prev_mode));
            end
            if (out_valid && !out_ready) check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check_eq("out_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("out_p", 64'(out_p), 64'(mon_e.p));
                    check_eq("out_tag", 64'(out_tag), 64'(mon_e.tag));
                    check_eq("out_mode", 64'(out_mode), 64'(mon_e.mode));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_p     = out_p;
            prev_tag   = out_tag;
            prev_mode  = out_mode;
            if (in_valid && in_ready) sb.push_back('{model_p(in_x, in_y, in_mode), in_tag, in_mode});
        end
    end

    task automatic drain();
        int c;
        c = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_one(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic mode, input logic [P_W-1:0] exp);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = x;
        in_y      = y;
        in_mode   = mode;
        in_tag    = TAG_W'(4'hA);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({name, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({name, "_lat"}, 64'(lat), 64'd3);
        check_eq({name, "_p"}, 64'(out_p), 64'(exp));
    endtask

    // mode_kind: 0 exact, 1 approx, 2 random; out_ready forced low for cycles bp_lo..bp_hi
    task automatic run_stream(input int n, input int mode_kind, input int vpct, input int rpct,
                              input int bp_lo, input int bp_hi);
        int sent, c;
        sent = 0;
        c    = 0;
        while (sent < n && c < 40 * n + 100) begin
            @(posedge clk); #1;
            out_ready = (c >= bp_lo && c <= bp_hi) ? 1'b0 : ($urandom_range(99) < rpct);
            in_valid  = $urandom_range(99) < vpct;
            in_x      = rand_op();
            in_y      = rand_op();
            in_mode   = (mode_kind == 2) ? 1'($urandom_range(1)) : 1'(mode_kind);
            in_tag    = TAG_W'(sent);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            c++;
        end
        check_eq("stream_sent", 64'(sent), 64'(n));
        drain();
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_p", 64'(out_p), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_out_mode", 64'(out_mode), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        run_one("apx_3x5", 16'd3, 16'd5, 1'b1, 32'h0000_0010);
        run_one("apx_m1x100", 16'hFFFF, 16'd100, 1'b1, 32'h0000_0000);
        run_one("ex_m1x100", 16'hFFFF, 16'd100, 1'b0, 32'hFFFF_FF9C);
        run_one("apx_4000x2", 16'h4000, 16'd2, 1'b1, 32'h0000_8000);
        run_one("ex_m3x7", 16'hFFFD, 16'd7, 1'b0, 32'hFFFF_FFEB);
        drain();

        run_stream(10000, 0, 100, 100, -1, -1);
        run_stream(3000, 2, 70, 60, -1, -1);
        run_stream(8, 2, 100, 100, 4, 9);

        // Full-rate stream: every op accepted and drained back to back
        base = n_out;
        for (int c = 0; c < 23; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = (c < 20);
            in_x      = rand_op();
            in_y      = rand_op();
            in_mode   = 1'($urandom_range(1));
            in_tag    = TAG_W'(c);
        end
        @(negedge clk); #1;
        check_eq("throughput", 64'(n_out - base), 64'd20);
        drain();

        // Reset with three operations in flight
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x     = rand_op();
            in_y     = rand_op();
            in_mode  = 1'(i);
            in_tag   = TAG_W'(i + 8);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("flight_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
        check_eq("rst_mid_p", 64'(out_p), 64'd0);
        check_eq("rst_mid_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("post_rst_valid", 64'(out_valid), 64'd0);
        end
        run_stream(200, 2, 80, 80, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
